// File: rtl/uart_rx_if.sv
// Byte stream carried from the UART receiver to its consumer, AXI-Stream style.
interface uart_rx_if;
  logic [7:0] axis_tdata;
  logic       axis_tvalid;
  logic       axis_tready;

  modport master (output axis_tdata, output axis_tvalid, input axis_tready);
  modport slave  (input axis_tdata, input axis_tvalid, output axis_tready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; holds each byte until the stream consumer takes it
// and flags framing errors and overruns as one-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_data,
  uart_rx_if.master axis,
  output logic      frame_err,
  output logic      overrun
);

  localparam int N_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF    = N_TICKS / 2;
  localparam int CW      = $clog2(N_TICKS);

  localparam logic [CW-1:0] CNT_LAST = CW'(N_TICKS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic          rx_s;

  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          load;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_data};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load always wins over a same-cycle handshake; overrun only when the old byte was not taken.
    tdata_d  = load ? shift_q : tdata_q;
    tvalid_d = load | (tvalid_q & ~axis.axis_tready);
    ovr_d    = load & tvalid_q & ~axis.axis_tready;
  end

  assign axis.axis_tdata  = tdata_q;
  assign axis.axis_tvalid = tvalid_q;
  assign frame_err        = ferr_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor logs handshakes and pulses.
module tb_uart_rx;
  localparam int NT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic fe, ov;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx),
    .axis      (bus),
    .frame_err (fe),
    .overrun   (ov)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_edge = 0;

  logic [7:0] rxq[$];
  int   fe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
  int   rise_cyc = 0, fall_cyc = 0;
  logic tv_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 2 time units after a posedge, so a negedge sees what the next edge will use.
  always @(negedge clk) begin
    tv_prev <= bus.axis_tvalid;
    fe_prev <= fe;
    ov_prev <= ov;
    if (bus.axis_tvalid && bus.axis_tready) rxq.push_back(bus.axis_tdata);
    if (bus.axis_tvalid && !tv_prev) rise_cyc <= cyc;
    if (!bus.axis_tvalid && tv_prev) fall_cyc <= cyc;
    if (fe) fe_cnt <= fe_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if ((fe && fe_prev) || (ov && ov_prev)) wide_cnt <= wide_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_edge = cyc + 1;
    repeat (NT) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (NT) tick();
    end
    rx = stop;
    repeat (NT) tick();
  endtask

  function automatic logic [31:0] byte_at(input int idx);
    if (idx < rxq.size()) return {24'h0, rxq[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n0, f0, o0, c3_seen;
    bus.axis_tready = 1'b1;

    repeat (3) tick();
    check("rst_tvalid", {31'h0, bus.axis_tvalid}, 32'd0);
    check("rst_tdata",  {24'h0, bus.axis_tdata},  32'h00);
    check("rst_ferr",   {31'h0, fe}, 32'd0);
    check("rst_ovr",    {31'h0, ov}, 32'd0);
    rst = 1'b0;
    idle(20);

    // Single byte, latency and one-cycle valid with ready held high
    n0 = rxq.size();
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("single_latency", rise_cyc - start_edge, 32'd154);
    check("single_width",   fall_cyc - rise_cyc,   32'd1);
    check("single_count",   rxq.size() - n0,       32'd1);
    check("single_data",    byte_at(n0),           32'hA5);

    // Back-to-back frames, no idle between them
    n0 = rxq.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(30);
    check("b2b_count", rxq.size() - n0, 32'd3);
    check("b2b_0",     byte_at(n0),     32'h00);
    check("b2b_1",     byte_at(n0 + 1), 32'hFF);
    check("b2b_2",     byte_at(n0 + 2), 32'h55);
    check("b2b_ferr",  fe_cnt - f0,     32'd0);
    check("b2b_ovr",   ov_cnt - o0,     32'd0);

    // Overrun: second byte replaces the unread first one
    bus.axis_tready = 1'b0;
    n0 = rxq.size(); o0 = ov_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(20);
    check("ovr_tvalid", {31'h0, bus.axis_tvalid}, 32'd1);
    check("ovr_tdata",  {24'h0, bus.axis_tdata},  32'h34);
    check("ovr_pulses", ov_cnt - o0,              32'd1);
    check("ovr_none_taken", rxq.size() - n0,      32'd0);
    bus.axis_tready = 1'b1;
    tick();
    check("ovr_tvalid_clr", {31'h0, bus.axis_tvalid}, 32'd0);
    idle(5);
    check("ovr_taken_count", rxq.size() - n0, 32'd1);
    check("ovr_taken_data",  byte_at(n0),     32'h34);

    // Short low glitch is rejected by the mid-start check
    n0 = rxq.size(); f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) tick();
    idle(200);
    check("glitch_bytes", rxq.size() - n0, 32'd0);
    check("glitch_ferr",  fe_cnt - f0,     32'd0);

    // Stop bit low, then a clean frame after the line recovers
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("ferr_pulses", fe_cnt - f0,     32'd1);
    check("ferr_bytes",  rxq.size() - n0, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(20);
    check("after_ferr_count", rxq.size() - n0, 32'd1);
    check("after_ferr_data",  byte_at(n0),     32'h81);

    // Line held low for 40 bit times
    n0 = rxq.size(); f0 = fe_cnt;
    rx = 1'b0;
    repeat (40 * NT) tick();
    idle(40);
    check("break_ferr",  fe_cnt - f0,     32'd1);
    check("break_bytes", rxq.size() - n0, 32'd0);
    send_frame(8'h7E, 1'b1);
    idle(20);
    check("after_break_count", rxq.size() - n0, 32'd1);
    check("after_break_data",  byte_at(n0),     32'h7E);

    // Reset pulse during data bit 4 of 0xC3
    n0 = rxq.size();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * NT + 8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tvalid", {31'h0, bus.axis_tvalid}, 32'd0);
        check("midrst_tdata",  {24'h0, bus.axis_tdata},  32'h00);
        check("midrst_ferr",   {31'h0, fe}, 32'd0);
        check("midrst_ovr",    {31'h0, ov}, 32'd0);
      end
    join
    // The line is still low after reset, so the frame tail restarts the receiver;
    // let that settle before the next real frame.
    idle(120);
    c3_seen = 0;
    for (int i = n0; i < rxq.size(); i++) if (rxq[i] == 8'hC3) c3_seen++;
    check("midrst_no_c3", c3_seen, 32'd0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("midrst_next", (rxq.size() > 0) ? {24'h0, rxq[rxq.size() - 1]} : 32'hFFFF_FFFF, 32'h5A);

    check("pulse_width", wide_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
